// File: rtl/sap_control_unit.sv
// sap_control_unit: SAP-1 ring-counter sequencer and opcode decoder driving the shared-bus control word.
module sap_control_unit #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       low_async_reset,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       low_pc_o_en,
  output logic       low_mar_i_en,
  output logic       low_ram_o_en,
  output logic       low_ir_i_en,
  output logic       low_ir_o_en,
  output logic       low_a_i_en,
  output logic       low_a_o_en,
  output logic       low_b_i_en,
  output logic       low_alu_o_en,
  output logic       alu_sub,
  output logic       low_out_i_en,
  output logic       halt,
  output logic [5:0] t_state
);
  typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, HALTED} state_t;
  state_t state_q, state_d;
  logic mem_op;
  // Advancing on the falling edge keeps the word stable half a cycle ahead of datapath capture.
  always_ff @(negedge clk or negedge low_async_reset)
    if (!low_async_reset) state_q <= T1;
    else state_q <= state_d;
  assign mem_op  = opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB;
  assign halt    = state_q == HALTED;
  assign t_state = halt ? 6'b0 : 6'b1 << state_q;
  always_comb begin
    state_d      = state_q;
    pc_inc       = 1'b0;
    low_pc_o_en  = 1'b1;
    low_mar_i_en = 1'b1;
    low_ram_o_en = 1'b1;
    low_ir_i_en  = 1'b1;
    low_ir_o_en  = 1'b1;
    low_a_i_en   = 1'b1;
    low_a_o_en   = 1'b1;
    low_b_i_en   = 1'b1;
    low_alu_o_en = 1'b1;
    alu_sub      = 1'b0;
    low_out_i_en = 1'b1;
    case (state_q)
      T1: state_d = T2;
      T2: state_d = T3;
      T3: state_d = T4;
      T4: state_d = opcode == OP_HLT ? HALTED : T5;
      T5: state_d = T6;
      T6: state_d = T1;
      HALTED: state_d = HALTED;
      default: state_d = T1;
    endcase
    // The whole word is held inactive while reset is low, even though the state already reads T1.
    if (low_async_reset) begin
      case (state_q)
        T1: begin
          low_pc_o_en  = 1'b0;
          low_mar_i_en = 1'b0;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          low_ram_o_en = 1'b0;
          low_ir_i_en  = 1'b0;
        end
        T4: begin
          low_ir_o_en  = !mem_op;
          low_mar_i_en = !mem_op;
          low_a_o_en   = opcode != OP_OUT;
          low_out_i_en = opcode != OP_OUT;
        end
        T5: begin
          low_ram_o_en = !mem_op;
          low_a_i_en   = opcode != OP_LDA;
          low_b_i_en   = !(opcode == OP_ADD || opcode == OP_SUB);
        end
        T6: begin
          low_alu_o_en = !(opcode == OP_ADD || opcode == OP_SUB);
          low_a_i_en   = !(opcode == OP_ADD || opcode == OP_SUB);
          alu_sub      = opcode == OP_SUB;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sap_control_unit.sv
// tb_sap_control_unit: randomized scoreboard bench comparing the control word against a microstep table model.
module tb_sap_control_unit;
  logic clk = 1'b0;
  logic low_async_reset = 1'b0;
  logic [3:0] opcode = 4'b0;
  logic pc_inc, low_pc_o_en, low_mar_i_en, low_ram_o_en, low_ir_i_en, low_ir_o_en;
  logic low_a_i_en, low_a_o_en, low_b_i_en, low_alu_o_en, alu_sub, low_out_i_en, halt;
  logic [5:0] t_state;

  sap_control_unit dut (
    .clk(clk), .low_async_reset(low_async_reset), .opcode(opcode),
    .pc_inc(pc_inc), .low_pc_o_en(low_pc_o_en), .low_mar_i_en(low_mar_i_en),
    .low_ram_o_en(low_ram_o_en), .low_ir_i_en(low_ir_i_en), .low_ir_o_en(low_ir_o_en),
    .low_a_i_en(low_a_i_en), .low_a_o_en(low_a_o_en), .low_b_i_en(low_b_i_en),
    .low_alu_o_en(low_alu_o_en), .alu_sub(alu_sub), .low_out_i_en(low_out_i_en),
    .halt(halt), .t_state(t_state)
  );

  always #5 clk = ~clk;

  // Active-set bits, order: pc_o mar_i ram_o ir_i ir_o a_i a_o b_i alu_o out_i
  localparam logic [9:0] PC_O = 10'b1000000000, MAR_I = 10'b0100000000, RAM_O = 10'b0010000000,
                         IR_I = 10'b0001000000, IR_O  = 10'b0000100000, A_I   = 10'b0000010000,
                         A_O  = 10'b0000001000, B_I   = 10'b0000000100, ALU_O = 10'b0000000010,
                         OUT_I = 10'b0000000001;

  int checks = 0, errors = 0;
  int m_step = 1;
  bit m_halt = 0, m_rst = 1;
  logic [3:0] m_op = 4'b0;
  logic [18:0] exp_q[$];

  function automatic logic [18:0] model(int step, bit hlt, bit rst_on, logic [3:0] op);
    logic [9:0] act = 10'b0;
    bit inc = 0, sub = 0;
    if (!rst_on && !hlt) begin
      if (step == 1) act = PC_O | MAR_I;
      if (step == 2) inc = 1;
      if (step == 3) act = RAM_O | IR_I;
      if (step == 4 && op inside {4'd0, 4'd1, 4'd2}) act = IR_O | MAR_I;
      if (step == 4 && op == 4'd14) act = A_O | OUT_I;
      if (step == 5 && op == 4'd0) act = RAM_O | A_I;
      if (step == 5 && op inside {4'd1, 4'd2}) act = RAM_O | B_I;
      if (step == 6 && op inside {4'd1, 4'd2}) act = ALU_O | A_I;
      if (step == 6 && op == 4'd2) sub = 1;
    end
    return {inc, ~act, sub, hlt && !rst_on, (hlt && !rst_on) ? 6'd0 : 6'd1 << (step - 1)};
  endfunction

  task automatic cycle(input logic [3:0] op, input bit rst_on);
    @(negedge clk);
    #1;
    if (m_rst) m_step = 1;
    else if (!m_halt) begin
      if (m_step == 4 && m_op == 4'd15) m_halt = 1;
      else m_step = m_step == 6 ? 1 : m_step + 1;
    end
    opcode = op;
    low_async_reset = !rst_on;
    m_op = op;
    m_rst = rst_on;
    if (rst_on) begin
      m_step = 1;
      m_halt = 0;
    end
    exp_q.push_back(model(m_step, m_halt, m_rst, m_op));
  endtask

  task automatic run_instr(input logic [3:0] op);
    repeat (6) cycle(op, 0);
  endtask

  initial begin
    logic [18:0] got, exp;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if ($countones({~low_pc_o_en, ~low_ram_o_en, ~low_ir_o_en, ~low_a_o_en, ~low_alu_o_en}) > 1) begin
        errors++;
        $display("FAIL bus t=%0t drivers(pc,ram,ir,a,alu active-low)=%b required at most one low", $time,
                 {low_pc_o_en, low_ram_o_en, low_ir_o_en, low_a_o_en, low_alu_o_en});
      end
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {pc_inc, low_pc_o_en, low_mar_i_en, low_ram_o_en, low_ir_i_en, low_ir_o_en, low_a_i_en,
               low_a_o_en, low_b_i_en, low_alu_o_en, low_out_i_en, alu_sub, halt, t_state};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL word t=%0t opcode=%h got=%b required=%b", $time, opcode, got, exp);
        end
      end
    end
  end

  initial begin
    int r, halted_for;
    logic [3:0] op;
    repeat (3) cycle(4'd0, 1);
    run_instr(4'd0);
    run_instr(4'd1);
    run_instr(4'd2);
    run_instr(4'd14);
    run_instr(4'd15);
    for (int i = 0; i < 10; i++) cycle(i[0] ? 4'd1 : 4'd15, 0);
    cycle(4'd15, 1);
    run_instr(4'd7);
    for (int i = 0; i < 12 && m_step != 4; i++) cycle(4'd1, 0);
    cycle(4'd1, 1);
    run_instr(4'd2);
    halted_for = 0;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 19);
      op = r < 4 ? 4'd0 : r < 8 ? 4'd1 : r < 12 ? 4'd2 : r < 15 ? 4'd14 : r == 15 ? 4'd15
           : 4'($urandom_range(3, 13));
      halted_for = m_halt ? halted_for + 1 : 0;
      cycle(op, $urandom_range(0, 99) < 2 || halted_for > 5);
    end
    repeat (2) cycle(4'd0, 0);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
